ser_tx4: RTL and testbench

//  Serial transmitter that drives the single-bit input `a` of the mod-4 ones-detector (m2).

---
 rtl/ser_pkg.sv | 12 +
 rtl/ser_tx4.sv | 75 +++++++
 tb/tb_ser_tx4.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and constants for the mod-4 ones-detector serial transmitter.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int         PH_W    = 2;
    localparam logic [1:0] PH_FIRE = 2'd3;

endpackage : ser_pkg

// File: rtl/ser_tx4.sv
// Purpose: shifts a WIDTH-bit word out MSB-first on `a`, tracking ones mod 4 to predict the detector's b.
// Latency: word accepted at negedge N drives bit k from negedge N+k to N+k+1; a word takes WIDTH periods.
// Backpressure: rdy is low while shifting except during the final bit; a load while rdy=0 is ignored.
module ser_tx4
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             rdy,
    output logic             busy,
    output logic             a,
    output logic [PH_W-1:0]  ph,
    output logic             exp_b
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit = (state == SHIFT) && (cnt == CW'(1));
    assign rdy      = (state == IDLE) || last_bit;
    assign busy     = (state == SHIFT);
    assign a        = (state == SHIFT) && sr[WIDTH-1];
    assign exp_b    = a && (ph == PH_FIRE);

    // All state moves on the falling edge so it lines up with the detector's flops.
    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            ph    <= '0;
        end else begin
            // ph counts the bit currently on the line, so it never resets between words.
            if (a) begin
                ph <= ph + PH_W'(1);
            end
            case (state)
                IDLE: begin
                    if (load) begin
                        sr    <= din;
                        cnt   <= CW'(WIDTH);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        if (load) begin
                            sr  <= din;
                            cnt <= CW'(WIDTH);
                        end else begin
                            sr    <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        sr  <= sr << 1;
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : ser_tx4

// File: tb/tb_ser_tx4.sv
// Directed bench for ser_tx4: each task drives a scenario and checks a, ph, exp_b, busy, rdy per bit period.
module tb_ser_tx4;

    logic       ck;
    logic       rst_n;
    logic [7:0] din;
    logic       load;
    logic       rdy;
    logic       busy;
    logic       a;
    logic [1:0] ph;
    logic       exp_b;

    int checks   = 0;
    int failures = 0;

    ser_tx4 #(.WIDTH(8)) dut (
        .ck    (ck),
        .rst_n (rst_n),
        .din   (din),
        .load  (load),
        .rdy   (rdy),
        .busy  (busy),
        .a     (a),
        .ph    (ph),
        .exp_b (exp_b)
    );

    initial begin
        ck = 1'b1;
        forever #5 ck = ~ck;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled on posedge; the DUT only moves on negedge.
    task automatic test_reset;
        rst_n = 1'b1;
        load  = 1'b0;
        din   = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (a !== 1'b0)     begin failures++; $display("FAIL reset_a got=%b exp=0", a); end
        checks++; if (rdy !== 1'b1)   begin failures++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ph !== 2'd0)    begin failures++; $display("FAIL reset_ph got=%0d exp=0", ph); end
        checks++; if (exp_b !== 1'b0) begin failures++; $display("FAIL reset_expb got=%b exp=0", exp_b); end
        @(posedge ck);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge ck);
            checks++;
            if ({a, rdy, busy, ph, exp_b} !== {1'b0, 1'b1, 1'b0, 2'd0, 1'b0}) begin
                failures++;
                $display("FAIL idle_outputs i=%0d got a=%b rdy=%b busy=%b ph=%0d expb=%b exp a=0 rdy=1 busy=0 ph=0 expb=0",
                         i, a, rdy, busy, ph, exp_b);
            end
        end
    endtask

    task automatic test_single_word;
        logic [7:0] a_exp;
        logic [7:0] b_exp;
        logic [1:0] ph_exp [8];
        a_exp  = 8'hF0;
        b_exp  = 8'b0001_0000;
        ph_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        din  = 8'hF0;
        load = 1'b1;
        @(posedge ck);
        load = 1'b0;
        din  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            checks++; if (a !== a_exp[7-k])     begin failures++; $display("FAIL single_a k=%0d got=%b exp=%b", k, a, a_exp[7-k]); end
            checks++; if (ph !== ph_exp[k])     begin failures++; $display("FAIL single_ph k=%0d got=%0d exp=%0d", k, ph, ph_exp[k]); end
            checks++; if (exp_b !== b_exp[7-k]) begin failures++; $display("FAIL single_expb k=%0d got=%b exp=%b", k, exp_b, b_exp[7-k]); end
            checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL single_busy k=%0d got=%b exp=1", k, busy); end
            checks++; if (rdy !== (k == 7))     begin failures++; $display("FAIL single_rdy k=%0d got=%b exp=%b", k, rdy, k == 7); end
            @(posedge ck);
        end
        checks++;
        if ({a, rdy, busy, ph} !== {1'b0, 1'b1, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL single_after got a=%b rdy=%b busy=%b ph=%0d exp a=0 rdy=1 busy=0 ph=0", a, rdy, busy, ph);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a_exp;
        logic [15:0] b_exp;
        logic [1:0]  ph_exp [16];
        a_exp  = 16'b1010_0101_0011_1100;
        b_exp  = 16'b0000_0001_0000_0100;
        ph_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3,
                   2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        din  = 8'hA5;
        load = 1'b1;
        @(posedge ck);
        load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++; if (a !== a_exp[15-k])     begin failures++; $display("FAIL b2b_a k=%0d got=%b exp=%b", k, a, a_exp[15-k]); end
            checks++; if (ph !== ph_exp[k])      begin failures++; $display("FAIL b2b_ph k=%0d got=%0d exp=%0d", k, ph, ph_exp[k]); end
            checks++; if (exp_b !== b_exp[15-k]) begin failures++; $display("FAIL b2b_expb k=%0d got=%b exp=%b", k, exp_b, b_exp[15-k]); end
            checks++; if (busy !== 1'b1)         begin failures++; $display("FAIL b2b_busy k=%0d got=%b exp=1", k, busy); end
            if (k == 7) begin
                checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy_last got=%b exp=1", rdy); end
                din  = 8'h3C;
                load = 1'b1;
            end
            if (k == 8) load = 1'b0;
            @(posedge ck);
        end
        checks++;
        if ({a, busy, ph} !== {1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL b2b_after got a=%b busy=%b ph=%0d exp a=0 busy=0 ph=0", a, busy, ph);
        end
    endtask

    task automatic test_load_held;
        logic [15:0] a_exp;
        logic [15:0] b_exp;
        logic [1:0]  ph_exp [16];
        a_exp  = 16'b1000_0001_0001_1000;
        b_exp  = 16'b0000_0000_0000_1000;
        ph_exp = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                   2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        din  = 8'h81;
        load = 1'b1;
        @(posedge ck);
        for (int k = 0; k < 16; k++) begin
            checks++; if (a !== a_exp[15-k])     begin failures++; $display("FAIL held_a k=%0d got=%b exp=%b", k, a, a_exp[15-k]); end
            checks++; if (ph !== ph_exp[k])      begin failures++; $display("FAIL held_ph k=%0d got=%0d exp=%0d", k, ph, ph_exp[k]); end
            checks++; if (exp_b !== b_exp[15-k]) begin failures++; $display("FAIL held_expb k=%0d got=%b exp=%b", k, exp_b, b_exp[15-k]); end
            checks++; if (rdy !== (k == 7 || k == 15)) begin failures++; $display("FAIL held_rdy k=%0d got=%b exp=%b", k, rdy, k == 7 || k == 15); end
            if (k == 7)       din = 8'h18;
            else if (k == 15) load = 1'b0;
            else              din = (k % 2 == 0) ? 8'hFF : 8'h7E;
            @(posedge ck);
        end
        checks++;
        if ({a, busy, rdy} !== {1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL held_after got a=%b busy=%b rdy=%b exp a=0 busy=0 rdy=1", a, busy, rdy);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] a_exp;
        logic [7:0] b_exp;
        logic [1:0] ph_exp [8];
        din  = 8'hFF;
        load = 1'b1;
        @(posedge ck);
        load = 1'b0;
        @(posedge ck);
        @(posedge ck);
        @(posedge ck);
        checks++;
        if ({a, ph, exp_b} !== {1'b1, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL abort_pre got a=%b ph=%0d expb=%b exp a=1 ph=3 expb=1", a, ph, exp_b);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({a, ph, busy, rdy, exp_b} !== {1'b0, 2'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL abort_reset got a=%b ph=%0d busy=%b rdy=%b expb=%b exp a=0 ph=0 busy=0 rdy=1 expb=0",
                     a, ph, busy, rdy, exp_b);
        end
        #1 rst_n = 1'b1;
        @(posedge ck);
        checks++; if ({a, busy} !== 2'b00) begin failures++; $display("FAIL abort_idle got a=%b busy=%b exp a=0 busy=0", a, busy); end
        a_exp  = 8'h0F;
        b_exp  = 8'b0000_0001;
        ph_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        din  = 8'h0F;
        load = 1'b1;
        @(posedge ck);
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (a !== a_exp[7-k])     begin failures++; $display("FAIL abort_a k=%0d got=%b exp=%b", k, a, a_exp[7-k]); end
            checks++; if (ph !== ph_exp[k])     begin failures++; $display("FAIL abort_ph k=%0d got=%0d exp=%0d", k, ph, ph_exp[k]); end
            checks++; if (exp_b !== b_exp[7-k]) begin failures++; $display("FAIL abort_expb k=%0d got=%b exp=%b", k, exp_b, b_exp[7-k]); end
            @(posedge ck);
        end
    endtask

    task automatic test_phase_persist;
        for (int w = 0; w < 3; w++) begin
            din  = 8'h01;
            load = 1'b1;
            @(posedge ck);
            load = 1'b0;
            for (int k = 0; k < 7; k++) @(posedge ck);
            checks++;
            if ({a, ph, exp_b} !== {1'b1, 2'(w), 1'b0}) begin
                failures++;
                $display("FAIL persist_last w=%0d got a=%b ph=%0d expb=%b exp a=1 ph=%0d expb=0", w, a, ph, exp_b, w);
            end
            @(posedge ck);
            checks++; if (ph !== 2'(w + 1)) begin failures++; $display("FAIL persist_ph w=%0d got=%0d exp=%0d", w, ph, w + 1); end
        end
        din  = 8'h80;
        load = 1'b1;
        @(posedge ck);
        load = 1'b0;
        checks++;
        if ({a, ph, exp_b} !== {1'b1, 2'd3, 1'b1}) begin
            failures++;
            $display("FAIL persist_msb got a=%b ph=%0d expb=%b exp a=1 ph=3 expb=1", a, ph, exp_b);
        end
        @(posedge ck);
        checks++;
        if ({a, ph, exp_b} !== {1'b0, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL persist_wrap got a=%b ph=%0d expb=%b exp a=0 ph=0 expb=0", a, ph, exp_b);
        end
        for (int k = 0; k < 7; k++) @(posedge ck);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_load_held();
        test_reset_mid_word();
        test_phase_persist();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ser_tx4
